// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
//
// Ports:
//   clk          block clock, rising edge
//   rst          asynchronous active-high reset
//   rx_i         serial input, idle high, asynchronous to clk
//   rx_data_o    byte at the FIFO head (meaningful only while rx_valid_o)
//   rx_valid_o   FIFO not empty
//   rx_ready_i   consumer accepts the head byte when rx_valid_o is also high
//   fifo_count_o FIFO occupancy, 0..FIFO_DEPTH
//   frame_err_o  sticky: a stop bit was sampled low
//   overrun_o    sticky: a byte arrived while the FIFO was full
//   clear_i      one-cycle clear of both sticky flags (a coincident set wins)
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_i,
  output logic [7:0]                   rx_data_o,
  output logic                         rx_valid_o,
  input  logic                         rx_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count_o,
  output logic                         frame_err_o,
  output logic                         overrun_o,
  input  logic                         clear_i
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronizer and falling-edge detect
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [1:0] live_q;
  logic       rx_prev;
  logic       rx_s;
  logic       rx_fall;

  assign rx_s = sync_q[1];

  // live_q marks when sync_q[1] carries a real sample rather than its reset
  // value, so a line already low at reset release is not taken as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      live_q  <= 2'b00;
      rx_prev <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rx_i};
      live_q  <= {live_q[0], 1'b1};
      rx_prev <= rx_s & live_q[1];
    end
  end

  assign rx_fall = rx_prev & ~rx_s;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_n;
  logic [15:0] timer, timer_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shift, shift_n;
  logic        push;
  logic        ferr_set;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shift <= shift_n;
    end
  end

  // Next-state: start check at half bit, data/stop sampled one full bit later
  always_comb begin
    state_n  = state;
    timer_n  = timer;
    idx_n    = idx;
    shift_n  = shift;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state)
      IDLE: begin
        if (rx_fall) begin
          state_n = START;
          timer_n = '0;
        end
      end
      START: begin
        if (timer == HALF_LAST) begin
          timer_n = '0;
          idx_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      DATA: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          shift_n = {rx_s, shift[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      STOP: begin
        if (timer == BIT_LAST) begin
          timer_n = '0;
          state_n = IDLE;
          if (rx_s) begin
            push = 1'b1;
          end else begin
            ferr_set = 1'b1;
          end
        end else begin
          timer_n = timer + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO with a registered head byte
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          wr_en;
  logic          ovr_set;
  logic [CW-1:0] count_n;

  assign full    = (fifo_count_o == FULL_COUNT);
  assign pop     = rx_valid_o & rx_ready_i;
  assign wr_en   = push & (~full | pop);
  assign ovr_set = push & full & ~pop;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_n = fifo_count_o;
    case ({wr_en, pop})
      2'b10:   count_n = fifo_count_o + CW'(1);
      2'b01:   count_n = fifo_count_o - CW'(1);
      default: count_n = fifo_count_o;
    endcase
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= shift;
    end
  end

  // Pointers, count, valid and head byte
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count_o <= '0;
      rx_valid_o   <= 1'b0;
      rx_data_o    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_count_o <= count_n;
      rx_valid_o   <= (count_n != '0);
      // Head follows the pushed byte when it becomes the only entry,
      // otherwise the next stored entry after a pop.
      if (wr_en && ((fifo_count_o == '0) || ((fifo_count_o == CW'(1)) && pop))) begin
        rx_data_o <= shift;
      end else if (pop && (fifo_count_o > CW'(1))) begin
        rx_data_o <= mem[rd_ptr + PW'(1)];
      end
    end
  end

  // Sticky flags; a set in the same cycle as clear_i wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (ferr_set) begin
        frame_err_o <= 1'b1;
      end else if (clear_i) begin
        frame_err_o <= 1'b0;
      end
      if (ovr_set) begin
        overrun_o <= 1'b1;
      end else if (clear_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001: Parameter CLKS_PER_BIT, default 434, is the number of clk cycles per serial bit (50 MHz / 115200 baud); legal range 8..65535.
REQ-002: Parameter FIFO_DEPTH, default 8, is the receive FIFO depth in bytes; it SHALL be a power of two, 2..64.
REQ-003: clk  input  1  single block clock, rising-edge active.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: rx_i  input  1  serial line driven by the SoC uart_tx pin; asynchronous to clk; idle high.
REQ-006: rx_data_o  output  8  byte at the FIFO head (first-word-fall-through).
REQ-007: rx_valid_o  output  1  FIFO not empty; rx_data_o is valid.
REQ-008: rx_ready_i  input  1  consumer accepts the head byte when rx_valid_o and rx_ready_i are both high.
REQ-009: fifo_count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010: frame_err_o  output  1  sticky flag: a stop bit was sampled low.
REQ-011: overrun_o  output  1  sticky flag: a byte was received while the FIFO was full.
REQ-012: clear_i  input  1  synchronous one-cycle clear of both sticky flags.

Function
REQ-013: rx_i SHALL pass through a two-flop synchronizer with reset value 1; all decisions use the synchronized value (2-cycle input latency).
REQ-014: Receiver FSM states: IDLE, START, DATA, STOP; 16-bit bit-timer, 3-bit bit-index, 8-bit shift register.
REQ-015: IDLE -> START on the synchronized falling edge of rx; the bit-timer loads to 0.
REQ-016: START: at bit-timer == CLKS_PER_BIT/2 - 1, if rx is low go to DATA (timer reset); if rx is high treat as a glitch and return to IDLE with no flag change.
REQ-017: DATA: sample rx at bit-timer == CLKS_PER_BIT - 1 (mid-bit); shift LSB first; after the 8th sample go to STOP.
REQ-018: STOP: sample at bit-timer == CLKS_PER_BIT - 1; if rx high, push the byte; if rx low, set frame_err_o, discard the byte; in both cases go to IDLE.
REQ-019: A falling edge detected in IDLE SHALL start a new frame with no extra dead time after STOP (back-to-back frames are supported).
REQ-020: The push occurs on the stop-sample cycle; rx_valid_o and the new fifo_count_o are visible the following cycle.
REQ-021: Pop when rx_valid_o && rx_ready_i; the next head byte appears the following cycle.
REQ-022: Full, push without pop: the byte is dropped, overrun_o is set, and FIFO contents are unchanged.
REQ-023: Full, push with pop in the same cycle: both are performed; the count stays at FIFO_DEPTH; overrun_o is not set.
REQ-024: Empty, push with rx_ready_i high: no pop occurs (rx_valid_o is low); the push is accepted; the count becomes 1.
REQ-025: Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
REQ-026: If clear_i coincides with a flag-setting event, the set wins (flag = 1 after that cycle).
REQ-027: rx_data_o is unspecified while rx_valid_o is low; the consumer SHALL NOT rely on it.

Reset
REQ-028: While rst is high: FSM = IDLE, timer/index/shift = 0, synchronizer = 1, pointers and count = 0, rx_valid_o = 0, fifo_count_o = 0, frame_err_o = 0, overrun_o = 0, rx_data_o = 0.
REQ-029: Reset asserted mid-frame SHALL abort the frame with no push; after deassertion the block waits in IDLE for a new falling edge.
REQ-030: If rx_i is low when reset releases, the block SHALL NOT start a frame until rx has been seen high and then falls.

Verification (CLKS_PER_BIT = 16, FIFO_DEPTH = 4)
REQ-031: Send frame 0xA5 with a valid stop bit, rx_ready_i = 1 -> rx_valid_o pulses one cycle with rx_data_o = 0xA5 and no flags set.
REQ-032: Send 0x3C with the stop bit held low -> no push, frame_err_o = 1; clear_i pulse -> frame_err_o = 0.
REQ-033: Send a 5-cycle low glitch on idle rx_i -> FSM returns to IDLE; fifo_count_o stays 0; no flags set.
REQ-034: With rx_ready_i = 0, send 0x01..0x05 -> fifo_count_o = 4, overrun_o = 1; drain returns 0x01, 0x02, 0x03, 0x04 in order.
REQ-035: FIFO full, assert rx_ready_i on the exact push cycle of the next byte -> count stays 4, overrun_o stays 0, and the order is preserved.
REQ-036: Assert rst during DATA bit 4 of frame 0xFF -> all outputs at reset values; the following frame 0x55 is received correctly.
